// File: rtl/mem_sized_pkg.sv
// Shared encodings for the sized data memory: access sizes, sequencer states
// and the byte-enable helper used by the write path.
package mem_sized_pkg;

    localparam int MAX_BYTES = 64;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Byte-enable for an access of the given size starting at byte lane 'lane'.
    function automatic logic [MAX_BYTES-1:0] lane_mask(input logic [1:0] size,
                                                       input logic [7:0] lane);
        logic [MAX_BYTES-1:0] base;
        case (size)
            SZ_BYTE: base = MAX_BYTES'(4'h1);
            SZ_HALF: base = MAX_BYTES'(4'h3);
            SZ_WORD: base = MAX_BYTES'(4'hF);
            default: base = '0;
        endcase
        return base << lane;
    endfunction

endpackage

// File: rtl/mem_sized_rdpipe.sv
// Read-return pipeline: RD_LAT stages of valid/data, flushed by reset so that
// reads in flight at reset never surface.
module mem_sized_rdpipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] valid_q, valid_d;
    logic [DATA_W-1:0] data_q [RD_LAT];
    logic [DATA_W-1:0] data_d [RD_LAT];

    always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_valid ? in_data : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < RD_LAT; i++) data_q[i] <= data_d[i];
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_data  = valid_q[RD_LAT-1] ? data_q[RD_LAT-1] : '0;

endmodule

// File: rtl/mem_sized.sv
// Byte-addressed data memory with byte/half/word accesses, pipelined reads,
// alignment error pulse and a post-reset clear sequencer.
module mem_sized
    import mem_sized_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              read,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrdata,
    output logic [DATA_W-1:0] rddata,
    output logic              rdvalid,
    output logic              busy,
    output logic              err
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int ROW_W  = ADDR_W - LANE_W;
    localparam int ROWS   = 2 ** ROW_W;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  mem_q [ROWS];

    logic [ROW_W-1:0]   row;
    logic [LANE_W-1:0]  lane;
    logic               misaligned, idle, wr_req, rd_req;

    logic               wr_en;
    logic [ROW_W-1:0]   wr_row;
    logic [BYTES-1:0]   wr_be;
    logic [DATA_W-1:0]  wr_word;
    logic [DATA_W-1:0]  rd_shift, size_mask, rd_data;

    assign row  = addr[ADDR_W-1:LANE_W];
    assign lane = addr[LANE_W-1:0];

    always_comb begin
        misaligned = (size == SZ_RSVD)
                  || (size == SZ_HALF && addr[0])
                  || (size == SZ_WORD && addr[1:0] != 2'b00);
        idle   = (state_q == ST_IDLE) && !rst;
        wr_req = idle && write && !read && !misaligned;
        rd_req = idle && read && !write && !misaligned;
        err_d  = idle && (write ^ read) && misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ROW_W'(ROWS - 1)) state_d = ST_IDLE;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CLEAR);
        err  = err_q;
    end

    // The clear sequencer and accepted writes share the single write port.
    always_comb begin
        wr_en   = 1'b0;
        wr_row  = row;
        wr_be   = '0;
        wr_word = '0;
        if (state_q == ST_CLEAR && !rst) begin
            wr_en  = 1'b1;
            wr_row = clr_cnt_q;
            wr_be  = '1;
        end else if (wr_req) begin
            wr_en   = 1'b1;
            wr_be   = BYTES'(lane_mask(size, 8'(lane)));
            wr_word = wrdata << {lane, 3'b000};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) mem_q[wr_row][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_comb begin
        case (size)
            SZ_BYTE: size_mask = DATA_W'(32'h0000_00FF);
            SZ_HALF: size_mask = DATA_W'(32'h0000_FFFF);
            default: size_mask = DATA_W'(32'hFFFF_FFFF);
        endcase
        rd_shift = mem_q[row] >> {lane, 3'b000};
        rd_data  = rd_req ? (rd_shift & size_mask) : '0;
    end

    mem_sized_rdpipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_req),
        .in_data   (rd_data),
        .out_valid (rdvalid),
        .out_data  (rddata)
    );

endmodule

// File: tb/tb_mem_sized.sv
// Drives three memories (read latency 1, 2, 3) with identical traffic and
// compares every output each cycle against a byte-array reference model.
module tb_mem_sized;

    localparam int ROWS = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0, write = 1'b0, read = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [9:0]  addr = '0;
    logic [31:0] wrdata = '0;

    logic [31:0] rddata1, rddata2, rddata3;
    logic        rdvalid1, rdvalid2, rdvalid3;
    logic        busy1, busy2, busy3;
    logic        err1, err2, err3;

    always #5 clk = ~clk;

    mem_sized #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .write(write), .read(read), .size(size), .addr(addr),
        .wrdata(wrdata), .rddata(rddata1), .rdvalid(rdvalid1), .busy(busy1), .err(err1));
    mem_sized #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .write(write), .read(read), .size(size), .addr(addr),
        .wrdata(wrdata), .rddata(rddata2), .rdvalid(rdvalid2), .busy(busy2), .err(err2));
    mem_sized #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .write(write), .read(read), .size(size), .addr(addr),
        .wrdata(wrdata), .rddata(rddata3), .rdvalid(rdvalid3), .busy(busy3), .err(err3));

    typedef struct {
        bit          v;
        logic [31:0] d;
    } rd_t;

    logic [7:0] model_mem [1024];
    rd_t        hist[$];
    int         clr_left = 0;
    bit         exp_busy = 1'b1;
    bit         exp_err  = 1'b0;
    bit         armed    = 1'b0;
    int         tests    = 0;
    int         fails    = 0;

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one clock edge; hist holds the last three launched
    // read results so latency L sees the entry launched L-1 edges ago.
    task automatic modelStep();
        rd_t e;
        e.v = 1'b0;
        e.d = '0;
        if (rst) begin
            foreach (model_mem[i]) model_mem[i] = 8'h00;
            clr_left = ROWS;
            exp_busy = 1'b1;
            exp_err  = 1'b0;
            hist.delete();
            hist.push_back(e);
            hist.push_back(e);
            armed = 1'b1;
        end else if (clr_left > 0) begin
            clr_left--;
            exp_busy = (clr_left > 0);
            exp_err  = 1'b0;
        end else begin
            int n;
            bit bad;
            n   = (size == 2'd3) ? 0 : (1 << size);
            bad = (n == 0) ? 1'b1 : ((int'(addr) % n) != 0);
            exp_err = (read ^ write) && bad;
            if (write && !read && !bad)
                for (int i = 0; i < n; i++) model_mem[int'(addr) + i] = wrdata[8*i +: 8];
            if (read && !write && !bad) begin
                e.v = 1'b1;
                for (int i = 0; i < n; i++) e.d[8*i +: 8] = model_mem[int'(addr) + i];
            end
        end
        hist.push_back(e);
        if (hist.size() > 3) void'(hist.pop_front());
    endtask

    task automatic checkOutput();
        if (!armed) return;
        checkOne("busy_lat1",    32'(busy1),    32'(exp_busy));
        checkOne("busy_lat2",    32'(busy2),    32'(exp_busy));
        checkOne("busy_lat3",    32'(busy3),    32'(exp_busy));
        checkOne("err_lat1",     32'(err1),     32'(exp_err));
        checkOne("err_lat2",     32'(err2),     32'(exp_err));
        checkOne("err_lat3",     32'(err3),     32'(exp_err));
        checkOne("rdvalid_lat1", 32'(rdvalid1), 32'(hist[2].v));
        checkOne("rdvalid_lat2", 32'(rdvalid2), 32'(hist[1].v));
        checkOne("rdvalid_lat3", 32'(rdvalid3), 32'(hist[0].v));
        checkOne("rddata_lat1",  rddata1,       hist[2].d);
        checkOne("rddata_lat2",  rddata2,       hist[1].d);
        checkOne("rddata_lat3",  rddata3,       hist[0].d);
    endtask

    task automatic applyStimulus(input bit r, input bit w, input bit rd, input logic [1:0] sz,
                                 input logic [9:0] a, input logic [31:0] d);
        rst = r; write = w; read = rd; size = sz; addr = a; wrdata = d;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic randomStep();
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 10'($urandom), $urandom);
    endtask

    initial begin
        logic [31:0] word;
        logic [9:0]  a;
        repeat (2) @(posedge clk);

        // Reset and clear sequence, with traffic that must be dropped.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
        repeat (ROWS) randomStep();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 10'h3FC, 32'h0);
        checkOne("busy_after_clear", 32'(busy1), 32'h0);
        checkOne("read_after_clear", rddata1, 32'h0);
        checkOne("rdvalid_after_clear", 32'(rdvalid1), 32'h1);

        // Word pattern fill, then byte reads of every address.
        for (int i = 0; i < 1024; i += 4) begin
            word = {8'(((7 * (i + 3)) % 1097) % 256), 8'(((23 * (i + 2)) % 1097) % 256),
                    8'(((17 * (i + 1)) % 1097) % 256), 8'(((13 * i) % 1097) % 256)};
            applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 10'(i), word);
        end
        for (int i = 0; i < 1024; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 10'(i), $urandom);
            if ($urandom_range(0, 7) == 0) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
        end

        // Mixed sizes, including read-after-write on the following cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 10'h010, 32'hA1B2C3D4);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 10'h012, 32'h0);
        checkOne("half_read", rddata1, 32'h0000A1B2);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 10'h011, 32'hFFFFFFEE);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 10'h010, 32'h0);
        checkOne("word_read", rddata1, 32'hA1B2EED4);

        // Rejected requests.
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 10'h011, 32'h0);
        checkOne("err_half_misaligned", 32'(err1), 32'h1);
        checkOne("rdvalid_misaligned", 32'(rdvalid1), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 10'h022, 32'hDEADBEEF);
        checkOne("err_word_misaligned", 32'(err1), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 10'h040, 32'h0);
        checkOne("err_reserved_size", 32'(err1), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
        checkOne("err_single_cycle", 32'(err1), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 10'h020, 32'h0);

        // Contention, then reset in the middle of a read stream.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 10'h010, 32'h12345678);
        checkOne("contention_rdvalid", 32'(rdvalid1), 32'h0);
        checkOne("contention_err", 32'(err1), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 10'h010, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 10'(4 * i), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 10'h00C, 32'h0);
        checkOne("rst_flush_lat3", 32'(rdvalid3), 32'h0);
        repeat (ROWS) randomStep();
        for (int i = 0; i < 1024; i += 4) applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 10'(i), 32'h0);

        // Back-to-back reads through the pipeline.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 10'(10'h100 + 4 * i), $urandom);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 10'(10'h100 + 4 * i), 32'h0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);

        // Random traffic, biased towards aligned accesses.
        for (int i = 0; i < 600; i++) begin
            a = 10'($urandom);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
